// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   bcd_state_t : converter FSM states
//   BCD_NINE    : digit value used when the result saturates on overflow
//   bcd_add3    : double-dabble digit adjust (+3 when the digit is >= 5)
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;

  // Only 4 bits are kept. No carry is passed to the next digit.
  function automatic logic [3:0] bcd_add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit cell of the double-dabble chain.
// The cell adjusts its digit, then shifts it left by one bit.
//   digit_i : current digit value
//   bit_i   : bit entering at the LSB (from the lower digit, or the binary MSB)
//   digit_o : adjusted and shifted digit
//   bit_o   : bit leaving at the MSB (to the next digit, or the overflow sticky)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       bit_i,
  output logic [3:0] digit_o,
  output logic       bit_o
);

  logic [3:0] adj;

  assign adj     = bcd_add3(digit_i);
  assign digit_o = {adj[2:0], bit_i};
  assign bit_o   = adj[3];

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (double-dabble). It converts one bit per clock.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake; in_bin is sampled on the accept edge
//   in_bin [W_IN]       : unsigned binary value
//   out_valid/out_ready : result handshake; outputs are held while waiting
//   out_bcd [4*DIGITS]  : packed digits; digit 0 (units) sits at the LSBs
//   out_ovf             : value >= 10^DIGITS; out_bcd saturates to all nines
//   out_blank [DIGITS]  : leading-zero mask; bit 0 is never set
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int W_IN   = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W_IN-1:0]       in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf,
  output logic [DIGITS-1:0]     out_blank
);

  localparam int CW = $clog2(W_IN + 1);
  localparam int AW = 4 * DIGITS;

  bcd_state_t        state_q, state_d;
  logic [W_IN-1:0]   sr_q, sr_d;
  logic [AW-1:0]     acc_q, acc_d, acc_sh, nines;
  logic              ovf_q, ovf_d, ovf_nx;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic [AW-1:0]     bcd_q, bcd_d;
  logic              oovf_q, oovf_d;
  logic [DIGITS-1:0] blank_q, blank_d, blank_nx;
  logic [DIGITS:0]   carry;

  // Adjust-and-shift chain. Digit 0 takes the binary MSB.
  // Whatever leaves the top digit means the value does not fit.
  assign carry[0] = sr_q[W_IN-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .bit_i   (carry[g]),
      .digit_o (acc_sh[4*g +: 4]),
      .bit_o   (carry[g+1])
    );
    assign nines[4*g +: 4] = BCD_NINE;
  end

  assign ovf_nx = ovf_q | carry[DIGITS];

  // Leading-zero mask of the final accumulator.
  // It is a running AND scanned from the top digit down.
  always_comb begin
    logic zrun;
    zrun     = 1'b1;
    blank_nx = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zrun        = zrun & (acc_sh[4*i +: 4] == 4'd0);
      blank_nx[i] = zrun;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    bcd_d   = bcd_q;
    oovf_d  = oovf_q;
    blank_d = blank_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = in_bin;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(W_IN);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_q << 1;
        acc_d = acc_sh;
        ovf_d = ovf_nx;
        cnt_d = cnt_q - 1'b1;
        // The result registers load on the same edge as the last shift.
        // This makes out_valid rise exactly W_IN edges after the accept.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          vld_d   = 1'b1;
          oovf_d  = ovf_nx;
          bcd_d   = ovf_nx ? nines : acc_sh;
          blank_d = ovf_nx ? '0 : blank_nx;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          bcd_d   = '0;
          oovf_d  = 1'b0;
          blank_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      bcd_q   <= '0;
      oovf_q  <= 1'b0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      bcd_q   <= bcd_d;
      oovf_q  <= oovf_d;
      blank_q <= blank_d;
    end
  end

  // in_ready is held low while reset is asserted, even though the state is IDLE.
  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = vld_q;
  assign out_bcd   = bcd_q;
  assign out_ovf   = oovf_q;
  assign out_blank = blank_q;

endmodule

// File: doc/bcd_seq_converter.md
# bcd_seq_converter

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It replaces combinational divide/modulo digit extraction on the display path. It takes a W_IN-bit unsigned value over a valid/ready handshake and returns DIGITS packed BCD digits, plus an overflow flag and a per-digit leading-zero blanking mask for the seven-segment driver.

## Interface
- W_IN, 10, width of binary input; 1..32
- DIGITS, 4, number of BCD output digits; 1..10
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_bin is valid
- in_ready  output  1  converter can accept a value
- in_bin  input  W_IN  unsigned binary value
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts result
- out_bcd  output  4*DIGITS  packed digits; digit i at [4i+3:4i], digit 0 = units
- out_ovf  output  1  value ≥ 10^DIGITS; out_bcd saturated
- out_blank  output  DIGITS  bit i = digit i is a leading zero; bit 0 always 0

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch in_bin into the shift register;
  - clear the BCD accumulator and the overflow sticky bit;
  - load bit counter with W_IN;
  - go to SHIFT.
- SHIFT: in_ready=0. Each cycle:
  - every digit ≥5 gets +3 (combinational adjust);
  - then the {accumulator, shift register} pair shifts left one bit, with the binary MSB entering digit 0 bit 0;
  - the bit shifted out of the top digit ORs into the overflow sticky;
  - the counter decrements. When the counter reaches 1, the next state is DONE.
- DONE: out_valid=1, and out_bcd/out_ovf/out_blank are held stable. When out_valid&out_ready, go to IDLE. No input accept in DONE.
- Overflow: if the sticky bit is set, out_bcd = all digits 9 and out_ovf=1.
- Blanking: out_blank[i]=1 iff digit i and all higher digits are 0, for i≥1. On overflow out_blank is all 0.
- Outputs are registered. out_bcd, out_ovf and out_blank are defined only while out_valid=1, and are 0 otherwise.
- Arithmetic:
  - the adjust is 4-bit with no carry between digits;
  - the shift register is W_IN bits;
  - the accumulator is exactly 4*DIGITS bits, with no hidden extra digit.

## Timing
- Reset values: in_ready=0 while rst is high, then 1 (state IDLE). out_valid=0, out_bcd=0, out_ovf=0, out_blank=0, counter=0.
- Latency:
  - accept at clock edge k;
  - SHIFT during edges k+1..k+W_IN;
  - out_valid=1 after edge k+W_IN.
- Throughput: one conversion per W_IN+2 cycles when out_ready is held high. The return to IDLE takes one edge, and the next accept takes one edge.
- Backpressure: with out_ready=0, DONE holds indefinitely and outputs must not change.
- in_bin is sampled only on the accept edge. Later changes to in_bin are ignored.
- rst asserted in any state, including mid-SHIFT:
  - next state is IDLE immediately (asynchronous);
  - all outputs return to their reset values;
  - a partial result is never presented.
- W_IN=1: exactly one SHIFT cycle.

## Structure
- Shared package bcd_pkg holds:
  - state typedef bcd_state_t {IDLE, SHIFT, DONE};
  - constant BCD_NINE=4'd9;
  - function bcd_add3(4-bit) returning the adjusted digit.
- Sub-module bcd_digit_adj: one 4-bit adjust-and-shift cell with carry-in (bit in) and carry-out (bit out). It is instantiated DIGITS times in a generate chain. Digit 0 carry-in is the binary MSB. The top digit's carry-out feeds the overflow sticky.
- Counter width is $clog2(W_IN+1).

## Test plan
- Default params, in_bin=9 with out_ready=1:
  - out_valid exactly 10 cycles after the accept edge;
  - out_bcd=16'h0009, out_ovf=0, out_blank=4'b1110.
- Default params, in_bin=1023, then in_bin=0 back-to-back:
  - first result out_bcd=16'h1023, blank=0000;
  - second result out_bcd=16'h0000, blank=1110;
  - second accept exactly 12 cycles after the first.
- DIGITS=3, W_IN=10, in_bin=1000 → out_ovf=1, out_bcd=12'h999, out_blank=000. Then in_bin=999 → out_ovf=0, out_bcd=12'h999.
- Backpressure: in_bin=512 with out_ready low for 20 cycles after out_valid:
  - out_bcd=16'h0512 stable throughout;
  - in_ready=0 until one edge after out_ready rises.
- Reset mid-SHIFT: assert rst 4 cycles after accepting 777. Required:
  - out_valid=0 and in_ready=1 after release;
  - a new accept of 42 yields 16'h0042 with no residue from the aborted conversion.
- Sweep W_IN=16, DIGITS=5 over random and boundary values (0, 9, 10, 65535):
  - compare out_bcd against a decimal reference model;
  - 65535 → 20'h65535, ovf=0.
